cache_mem_arbiter: RTL
======================

# cache_mem_arbiter

Arbitrates the single downstream memory port between the instruction-cache refill path and the data-cache refill/writeback path. It sits between the two cache blocks and the AXI4 bridge. It latches one request at a time, drives it to memory, and returns the result to the owning cache with a one-cycle completion pulse. Arbitration is two-way round-robin, and a response timeout guarantees forward progress.

## Interface
- TIMEOUT, 255: maximum cycles to wait for mem_ack while granted before aborting; legal 1..255.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_req  in  1  I-cache read request; held high until i_ok.
- i_addr  in  64  I-cache fetch address.
- i_rdata  out  32  fetched instruction word; valid only while i_ok=1.
- i_ok  out  1  one-cycle completion pulse to I-cache.
- d_req  in  1  D-cache request; held high until d_ok.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  64  D-cache address.
- d_wdata  in  64  write data.
- d_wstrb  in  8  byte strobes for writes.
- d_rdata  out  64  read data; valid only while d_ok=1.
- d_ok  out  1  one-cycle completion pulse to D-cache.
- mem_req  out  1  request to memory bridge; level, held until mem_ack.
- mem_we  out  1  write enable to bridge.
- mem_addr  out  64  address to bridge.
- mem_wdata  out  64  write data to bridge.
- mem_wstrb  out  8  strobes to bridge.
- mem_rdata  in  64  read data from bridge; sampled when mem_ack=1.
- mem_ack  in  1  one-cycle completion from bridge.
- bus_err  out  1  one-cycle pulse, coincident with i_ok/d_ok, when the transaction timed out.

## Operation
- States: IDLE, GRANT_I, GRANT_D, RESP.
- IDLE behaviour:
  - Neither request high: stay in IDLE.
  - Exactly one request high: go to that requester's GRANT state.
  - Both high: grant the requester not recorded in last_grant.
  - Latch requester id, address, we, wdata and wstrb on entry. For I grants, latched we=0 and wstrb=0.
- last_grant: 1-bit register, reset value = D, so the first tie goes to I. It is updated when a GRANT state is entered.
- GRANT_I / GRANT_D behaviour:
  - mem_req=1; mem_* driven from the latched registers, never from live requester inputs.
  - A 9-bit wait counter clears on entry and increments each cycle mem_ack=0.
  - mem_ack=1: capture mem_rdata into the response register, then go to RESP.
  - Counter reaches TIMEOUT with no ack: capture 0, set err flag, then go to RESP.
- RESP behaviour:
  - Assert the owner's ok for exactly this cycle; bus_err = err flag.
  - i_rdata = latched addr[2] ? resp[63:32] : resp[31:0].
  - d_rdata = resp. Writes return resp unchanged, and the D-cache ignores it.
  - Next state is always IDLE. Requests are not evaluated in RESP, so a requester still holding req during its ok cycle is never re-granted.
- mem_ack arriving in IDLE or RESP is ignored.
- Outputs are Moore-decoded from state and latched registers.
- Reset values of all outputs:
  - i_ok, d_ok, bus_err, mem_req, mem_we = 0.
  - mem_addr, mem_wdata, mem_wstrb, i_rdata, d_rdata = 0.
  - state = IDLE, counter = 0, err = 0.
- Reset asserted mid-transaction: return to IDLE at once, drop mem_req, and emit no ok pulse. A late mem_ack after reset release is ignored.

## Timing
- Request high at edge N in IDLE: mem_req=1 from cycle N+1.
- mem_ack at cycle N+k: ok pulse at N+k+1; IDLE at N+k+2. The earliest next grant drives mem_req at N+k+3.
- Minimum turnaround is 3 cycles for a zero-wait bridge; no combinational path from mem_ack to ok.
- Timeout: with mem_req first high at cycle G and no ack, ok plus bus_err assert at G+TIMEOUT+1.
- Requesters must deassert req by the edge after their ok. A req still high at the next IDLE is treated as a new request.
- Fairness: with both requesters continuously requesting, grants strictly alternate I, D, I, D.

## Test plan
- Single I read:
  - Stimulus: i_addr=0x8000_0004; bridge returns mem_rdata=0x11223344_55667788 after 2 cycles.
  - Response: mem_addr=0x8000_0004, mem_we=0; i_ok pulse with i_rdata=0x11223344; d_ok stays 0.
- Single D write:
  - Stimulus: d_addr=0x8000_1000, d_wdata=0xDEADBEEF_CAFEF00D, d_wstrb=0xF0.
  - Response: mem_we=1 and mem_wstrb=0xF0 for the whole grant; d_ok one cycle after ack.
- Simultaneous requests from reset:
  - Stimulus: i_req and d_req high in the same cycle.
  - Response: I granted first, D next; mem_addr switches only after RESP and IDLE.
- Continuous contention:
  - Stimulus: both requests kept asserted for 6 transactions.
  - Response: grant order I, D, I, D, I, D; no requester is ever granted twice in a row.
- Timeout:
  - Stimulus: TIMEOUT=4, bridge never acks a D read.
  - Response: d_ok, bus_err=1 and d_rdata=0 at mem_req start+5; mem_req low in the same cycle.
- Reset mid-grant:
  - Stimulus: assert rst two cycles into GRANT_I, then ack after release.
  - Response: all outputs 0 immediately; no i_ok; the stray ack is ignored; the next i_req is served normally.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: two-way round-robin arbiter that shares one memory port
// between the I-cache refill path and the D-cache refill/writeback path.
module cache_mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [63:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ok,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  input  logic [7:0]  d_wstrb,
  output logic [63:0] d_rdata,
  output logic        d_ok,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wstrb,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err
);

  // state   | meaning
  // IDLE    | no owner; requests are evaluated
  // GRANT_I | I-cache transaction on the memory port
  // GRANT_D | D-cache transaction on the memory port
  // RESP    | ok pulse to the owner; requests are not evaluated
  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RESP} state_t;

  localparam logic [8:0] TIMEOUT_CNT = 9'(TIMEOUT);
  localparam logic       OWNER_I     = 1'b0;
  localparam logic       OWNER_D     = 1'b1;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [63:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wstrb_q, wstrb_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [63:0] resp_q, resp_d;
  logic        err_q, err_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= OWNER_D;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      cnt_q        <= '0;
      resp_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      cnt_q        <= cnt_d;
      resp_q       <= resp_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    cnt_d        = cnt_q;
    resp_d       = resp_q;
    err_d        = err_q;
    unique case (state_q)
      IDLE: begin
        // On a tie the requester that did not win last time is served.
        if (i_req && (!d_req || last_grant_q == OWNER_D)) begin
          state_d      = GRANT_I;
          last_grant_d = OWNER_I;
          addr_d       = i_addr;
          we_d         = 1'b0;
          wdata_d      = '0;
          wstrb_d      = '0;
          cnt_d        = '0;
          err_d        = 1'b0;
        end else if (d_req) begin
          state_d      = GRANT_D;
          last_grant_d = OWNER_D;
          addr_d       = d_addr;
          we_d         = d_we;
          wdata_d      = d_wdata;
          wstrb_d      = d_wstrb;
          cnt_d        = '0;
          err_d        = 1'b0;
        end
      end
      GRANT_I, GRANT_D: begin
        if (mem_ack) begin
          resp_d  = mem_rdata;
          state_d = RESP;
        end else if (cnt_q == TIMEOUT_CNT) begin
          resp_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on state and latched registers, never on live inputs.
  assign mem_req   = (state_q == GRANT_I) || (state_q == GRANT_D);
  assign mem_we    = mem_req && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;

  assign i_ok    = (state_q == RESP) && (last_grant_q == OWNER_I);
  assign d_ok    = (state_q == RESP) && (last_grant_q == OWNER_D);
  assign bus_err = (state_q == RESP) && err_q;
  assign i_rdata = i_ok ? (addr_q[2] ? resp_q[63:32] : resp_q[31:0]) : '0;
  assign d_rdata = d_ok ? resp_q : '0;

endmodule
